// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding instr_dec: holds the PC, reads a synchronous
// instruction memory and hands each word over on the triggered/trigger handshake.
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 12
`endif

module instr_fetch #(
    parameter int                     INSTR_WIDTH = `INSTR_WIDTH,
    parameter int                     ADDR_WIDTH  = 8,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = 12'hFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   triggered,
    input  logic                   trigger,
    output logic                   check_busy,
    input  logic                   indicate_busy,
    input  logic                   branch_en,
    input  logic [ADDR_WIDTH-1:0]  branch_addr,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   halted
);

    localparam logic [2:0] FETCH   = 3'd0;
    localparam logic [2:0] WAIT    = 3'd1;
    localparam logic [2:0] PRESENT = 3'd2;
    localparam logic [2:0] HOLD    = 3'd3;
    localparam logic [2:0] HALT    = 3'd4;

    logic [2:0]             state_r;
    logic [2:0]             state_s;
    logic [ADDR_WIDTH-1:0]  pc_r;
    logic [ADDR_WIDTH-1:0]  pc_s;
    logic [INSTR_WIDTH-1:0] instr_r;
    logic [INSTR_WIDTH-1:0] instr_s;
    logic                   rd_en_r;
    logic                   trig_r;
    logic                   chk_busy_r;
    logic                   halted_r;
    logic                   xfer_s;

    // Next state, next PC and instruction capture; a branch overrides everything
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        instr_s = instr_r;
        xfer_s  = trig_r & trigger;
        if (branch_en) begin
            state_s = FETCH;
            pc_s    = branch_addr;
        end else begin
            case (state_r)
                FETCH: begin
                    // FETCH without a read on the bus only happens straight out of reset
                    if (rd_en_r) begin
                        state_s = WAIT;
                    end else begin
                        state_s = FETCH;
                    end
                end
                WAIT: begin
                    instr_s = mem_rdata;
                    pc_s    = pc_r + ADDR_WIDTH'(1);
                    state_s = PRESENT;
                end
                PRESENT: begin
                    if (!xfer_s) begin
                        state_s = PRESENT;
                    end else if (instr_r == HALT_WORD) begin
                        state_s = HALT;
                    end else if (indicate_busy) begin
                        state_s = HOLD;
                    end else begin
                        state_s = FETCH;
                    end
                end
                HOLD: begin
                    if (indicate_busy) begin
                        state_s = HOLD;
                    end else begin
                        state_s = FETCH;
                    end
                end
                HALT: begin
                    state_s = HALT;
                end
                default: begin
                    state_s = FETCH;
                end
            endcase
        end
    end

    // State register; outputs are registered from the next state so none is combinational
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= FETCH;
            pc_r       <= ADDR_WIDTH'(0);
            instr_r    <= INSTR_WIDTH'(0);
            rd_en_r    <= 1'b0;
            trig_r     <= 1'b0;
            chk_busy_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            instr_r    <= instr_s;
            rd_en_r    <= (state_s == FETCH);
            trig_r     <= (state_s == PRESENT);
            chk_busy_r <= (state_s == PRESENT) || (state_s == HOLD);
            halted_r   <= (state_s == HALT);
        end
    end

    assign mem_rd_en  = rd_en_r;
    assign mem_addr   = pc_r;
    assign pc         = pc_r;
    assign instr      = instr_r;
    assign triggered  = trig_r;
    assign check_busy = chk_busy_r;
    assign halted     = halted_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: cycle table, directed corner sequences
// and a randomized run scored against a transaction-level fetch model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [11:0] mem_rdata = 12'h000;
    logic [11:0] instr;
    logic        triggered;
    logic        trigger = 1'b0;
    logic        check_busy;
    logic        indicate_busy = 1'b0;
    logic        branch_en = 1'b0;
    logic [7:0]  branch_addr = 8'h00;
    logic [7:0]  pc;
    logic        halted;

    logic [11:0] mem [256];
    int nchk = 0;
    int nerr = 0;

    instr_fetch dut (
        .clk(clk), .rst(rst), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .instr(instr), .triggered(triggered), .trigger(trigger),
        .check_busy(check_busy), .indicate_busy(indicate_busy), .branch_en(branch_en),
        .branch_addr(branch_addr), .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data one cycle after the strobe, garbage otherwise
    always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 12'($urandom);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        trg, bsy, br;
        logic [7:0]  ba;
        logic        e_trig;
        logic [11:0] e_instr;
        logic        e_rd;
        logic [7:0]  e_addr;
        logic        e_cb, e_halt;
        logic [7:0]  e_pc;
    } vec_t;
    vec_t tbl [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; trigger = 1'b0; indicate_busy = 1'b0; branch_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_trig(input string nm);
        int n = 0;
        while (!triggered && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " triggered"}, 32'(triggered), 32'd1);
    endtask

    task automatic take();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    initial begin
        int          exp_addr;
        int          nx;
        logic        pv_trig, pv_xfer, pv_br;
        logic [11:0] pv_instr;
        logic [7:0]  pv_ba;
        logic        xfer;

        for (int i = 0; i < 256; i++) mem[i] = 12'h000;
        mem[0] = 12'd2048; mem[1] = 12'd1656; mem[2] = 12'd5;
        mem[3] = 12'h321;  mem[8'h40] = 12'h7A5;

        // cycle table: row 1 is the first cycle after reset is sampled low
        tbl[0]  = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'd0,   1'b0,8'h00,1'b0,1'b0,8'h00};
        tbl[1]  = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'd0,   1'b1,8'h00,1'b0,1'b0,8'h00};
        tbl[2]  = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'd0,   1'b0,8'h00,1'b0,1'b0,8'h00};
        tbl[3]  = '{1'b1,1'b0,1'b0,8'h00, 1'b1,12'd2048,1'b0,8'h01,1'b1,1'b0,8'h01};
        tbl[4]  = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'd2048,1'b1,8'h01,1'b0,1'b0,8'h01};
        tbl[5]  = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'd2048,1'b0,8'h01,1'b0,1'b0,8'h01};
        tbl[6]  = '{1'b1,1'b0,1'b0,8'h00, 1'b1,12'd1656,1'b0,8'h02,1'b1,1'b0,8'h02};
        tbl[7]  = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'd1656,1'b1,8'h02,1'b0,1'b0,8'h02};
        tbl[8]  = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'd1656,1'b0,8'h02,1'b0,1'b0,8'h02};
        tbl[9]  = '{1'b1,1'b1,1'b0,8'h00, 1'b1,12'd5,   1'b0,8'h03,1'b1,1'b0,8'h03};
        tbl[10] = '{1'b1,1'b1,1'b0,8'h00, 1'b0,12'd5,   1'b0,8'h03,1'b1,1'b0,8'h03};
        tbl[11] = '{1'b1,1'b1,1'b0,8'h00, 1'b0,12'd5,   1'b0,8'h03,1'b1,1'b0,8'h03};
        tbl[12] = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'd5,   1'b0,8'h03,1'b1,1'b0,8'h03};
        tbl[13] = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'd5,   1'b1,8'h03,1'b0,1'b0,8'h03};
        tbl[14] = '{1'b1,1'b0,1'b1,8'h40, 1'b0,12'd5,   1'b0,8'h03,1'b0,1'b0,8'h03};
        tbl[15] = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'd5,   1'b1,8'h40,1'b0,1'b0,8'h40};
        tbl[16] = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'd5,   1'b0,8'h40,1'b0,1'b0,8'h40};
        tbl[17] = '{1'b1,1'b0,1'b0,8'h00, 1'b1,12'h7A5, 1'b0,8'h41,1'b1,1'b0,8'h41};

        repeat (2) @(posedge clk);
        for (int r = 0; r < 18; r++) begin
            @(negedge clk);
            chk($sformatf("row%0d triggered", r),  32'(triggered),  32'(tbl[r].e_trig));
            chk($sformatf("row%0d instr", r),      32'(instr),      32'(tbl[r].e_instr));
            chk($sformatf("row%0d mem_rd_en", r),  32'(mem_rd_en),  32'(tbl[r].e_rd));
            chk($sformatf("row%0d mem_addr", r),   32'(mem_addr),   32'(tbl[r].e_addr));
            chk($sformatf("row%0d check_busy", r), 32'(check_busy), 32'(tbl[r].e_cb));
            chk($sformatf("row%0d halted", r),     32'(halted),     32'(tbl[r].e_halt));
            chk($sformatf("row%0d pc", r),         32'(pc),         32'(tbl[r].e_pc));
            rst = 1'b0;
            trigger = tbl[r].trg; indicate_busy = tbl[r].bsy;
            branch_en = tbl[r].br; branch_addr = tbl[r].ba;
        end

        // stall: decoder withholds trigger while 1656 is presented
        do_reset();
        wait_trig("stall first");
        take();
        wait_trig("stall second");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall triggered", 32'(triggered), 32'd1);
            chk("stall instr",     32'(instr),     32'd1656);
            chk("stall mem_rd_en", 32'(mem_rd_en), 32'd0);
            chk("stall pc",        32'(pc),        32'd2);
        end
        take();

        // halt word, then branch out of halt
        mem[0] = 12'h111; mem[1] = 12'hFFF;
        do_reset();
        wait_trig("halt first");
        take();
        wait_trig("halt second");
        chk("halt instr", 32'(instr), 32'hFFF);
        take();
        chk("halt halted",     32'(halted),     32'd1);
        chk("halt triggered",  32'(triggered),  32'd0);
        chk("halt check_busy", 32'(check_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt no read", 32'(mem_rd_en), 32'd0);
            chk("halt held",    32'(halted),    32'd1);
        end
        branch_en = 1'b1; branch_addr = 8'h10;
        @(negedge clk);
        branch_en = 1'b0;
        chk("unhalt halted",    32'(halted),    32'd0);
        chk("unhalt mem_rd_en", 32'(mem_rd_en), 32'd1);
        chk("unhalt mem_addr",  32'(mem_addr),  32'h10);

        // PC wrap at 8'hFF, then reset in the middle of PRESENT
        mem[8'hFF] = 12'h5A5;
        do_reset();
        branch_en = 1'b1; branch_addr = 8'hFF;
        @(negedge clk);
        branch_en = 1'b0;
        chk("wrap mem_addr", 32'(mem_addr), 32'hFF);
        wait_trig("wrap");
        chk("wrap instr", 32'(instr), 32'h5A5);
        chk("wrap pc",    32'(pc),    32'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst triggered",  32'(triggered),  32'd0);
        chk("midrst pc",         32'(pc),         32'd0);
        chk("midrst instr",      32'(instr),      32'd0);
        chk("midrst mem_rd_en",  32'(mem_rd_en),  32'd0);
        chk("midrst check_busy", 32'(check_busy), 32'd0);
        rst = 1'b0;

        // randomized run: every accepted word must be mem[] at the model's address
        for (int i = 0; i < 256; i++) mem[i] = 12'($urandom_range(0, 12'hFFE));
        do_reset();
        exp_addr = 0; nx = 0;
        pv_trig = 1'b0; pv_xfer = 1'b0; pv_br = 1'b0; pv_instr = 12'h000; pv_ba = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) @(negedge clk);
            if (pv_trig && !pv_xfer && !pv_br) begin
                chk("rand hold triggered", 32'(triggered), 32'd1);
                chk("rand hold instr",     32'(instr),     32'(pv_instr));
            end
            if (pv_br) begin
                chk("rand branch rd_en", 32'(mem_rd_en), 32'd1);
                chk("rand branch addr",  32'(mem_addr),  32'(pv_ba));
            end
            trigger       = ($urandom_range(0, 99) < 60);
            indicate_busy = ($urandom_range(0, 99) < 30);
            branch_en     = ($urandom_range(0, 99) < 3);
            branch_addr   = 8'($urandom);
            xfer = triggered && trigger;
            if (xfer) begin
                chk("rand xfer instr", 32'(instr), 32'(mem[exp_addr[7:0]]));
                exp_addr = (exp_addr + 1) % 256;
                nx++;
            end
            if (branch_en) exp_addr = int'(branch_addr);
            pv_trig = triggered; pv_xfer = xfer; pv_br = branch_en;
            pv_instr = instr; pv_ba = branch_addr;
        end
        trigger = 1'b0; branch_en = 1'b0; indicate_busy = 1'b0;
        chk("rand liveness", 32'(nx >= 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
